// File: rtl/ps2_rx_pkg.sv
// ----------------------------------------------------------------------------
// ps2_rx_pkg
//   Shared types and constants for the PS/2 frame receiver.
//   - state_t    : deframer FSM states
//   - err_code_t : error code reported on o_err_code
//   - PS2_BREAK / PS2_EXT : scancode prefix bytes
// ----------------------------------------------------------------------------
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_PARITY  = 2'd1,
        ERR_FRAMING = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
//   Synchronises one asynchronous PS/2 line into i_clk, glitch-filters it and
//   produces a one-cycle strobe when the filtered level falls 1->0.
//   Parameters:
//     SYNC_STAGES : synchroniser depth (>=2)
//     FILTER_LEN  : consecutive differing samples needed to flip the level (>=1)
//   Ports:
//     i_clk    in  1  system clock
//     i_reset  in  1  asynchronous active-high reset (line assumed idle high)
//     i_line   in  1  raw asynchronous line
//     o_level  out 1  filtered line level
//     o_fall   out 1  one-cycle strobe, filtered level just went 1->0
// ----------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   fall_q;
    logic                   synced;
    logic                   flip;

    assign synced = sync_q[SYNC_STAGES-1];
    // The level flips on the FILTER_LEN-th consecutive differing sample.
    assign flip   = (synced != level_q) && (cnt_q == CNT_W'(FILTER_LEN - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
            fall_q <= flip && level_q;
            if (synced == level_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                cnt_q   <= '0;
                level_q <= synced;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_level = level_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// ----------------------------------------------------------------------------
// ps2_frame_rx
//   PS/2 device-to-host frame receiver. Filters the raw PS/2 clock/data lines
//   and deframes 11-bit frames (start, 8 data LSB first, odd parity, stop).
//   Optional feature macro: PS2_BREAK_TRACK_EN
//     defined   : 0xE0/0xF0 prefixes are absorbed into o_extended/o_break
//                 flags reported alongside the following byte.
//     undefined : every accepted byte strobes o_valid; o_break/o_extended = 0.
//   Ports:
//     i_clk        in  1  50 MHz system clock
//     i_reset      in  1  asynchronous active-high reset
//     i_ps2_clk    in  1  raw PS/2 clock
//     i_ps2_data   in  1  raw PS/2 data
//     o_data       out 8  last received byte, held
//     o_valid      out 1  one-cycle strobe, o_data updated
//     o_err        out 1  one-cycle strobe, frame discarded
//     o_err_code   out 2  01 parity, 10 framing, 11 timeout; held
//     o_break      out 1  0xF0 preceded o_data (feature only)
//     o_extended   out 1  0xE0 preceded o_data (feature only)
// ----------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_break,
    output logic       o_extended
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic clk_f;
    logic clk_fall;
    logic data_f;
    logic data_fall_unused;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_line  (i_ps2_clk),
        .o_level (clk_f),
        .o_fall  (clk_fall)
    );

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_data_filter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_line  (i_ps2_data),
        .o_level (data_f),
        .o_fall  (data_fall_unused)
    );

    state_t     state_q;
    logic [2:0] bitcnt_q;
    logic [7:0] shift_q;
    logic       parity_q;
    logic [TMO_W-1:0] tmo_q;
    logic       tmo_hit;

    logic [7:0] data_q;
    logic       valid_q;
    logic       err_q;
    err_code_t  err_code_q;
    logic       break_q;
    logic       ext_q;
`ifdef PS2_BREAK_TRACK_EN
    logic       brk_flag_q;
    logic       ext_flag_q;
`endif

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            break_q    <= 1'b0;
            ext_q      <= 1'b0;
`ifdef PS2_BREAK_TRACK_EN
            brk_flag_q <= 1'b0;
            ext_flag_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            break_q <= 1'b0;
            ext_q   <= 1'b0;

            if (state_q == IDLE || clk_fall)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TMO_W'(1);

            case (state_q)
                IDLE: begin
                    // A falling edge with data high is a spurious edge; ignore it.
                    if (clk_fall && !data_f) begin
                        state_q  <= DATA;
                        bitcnt_q <= '0;
                    end
                end
                DATA: begin
                    if (clk_fall) begin
                        shift_q[bitcnt_q] <= data_f;
                        bitcnt_q          <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7)
                            state_q <= PARITY;
                    end
                end
                PARITY: begin
                    if (clk_fall) begin
                        parity_q <= data_f;
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    if (clk_fall) begin
                        state_q <= IDLE;
                        if (!data_f || !(^{shift_q, parity_q})) begin
                            // Framing outranks parity.
                            err_q      <= 1'b1;
                            err_code_q <= !data_f ? ERR_FRAMING : ERR_PARITY;
`ifdef PS2_BREAK_TRACK_EN
                            brk_flag_q <= 1'b0;
                            ext_flag_q <= 1'b0;
`endif
                        end else begin
`ifdef PS2_BREAK_TRACK_EN
                            if (shift_q == PS2_EXT) begin
                                ext_flag_q <= 1'b1;
                            end else if (shift_q == PS2_BREAK) begin
                                brk_flag_q <= 1'b1;
                            end else begin
                                valid_q    <= 1'b1;
                                data_q     <= shift_q;
                                break_q    <= brk_flag_q;
                                ext_q      <= ext_flag_q;
                                brk_flag_q <= 1'b0;
                                ext_flag_q <= 1'b0;
                            end
`else
                            valid_q <= 1'b1;
                            data_q  <= shift_q;
`endif
                        end
                    end
                end
            endcase

            // Timeout only applies mid-frame, and a coincident strobe wins.
            if (state_q != IDLE && !clk_fall && tmo_hit) begin
                state_q    <= IDLE;
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
`ifdef PS2_BREAK_TRACK_EN
                brk_flag_q <= 1'b0;
                ext_flag_q <= 1'b0;
`endif
            end
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;
    assign o_break    = break_q;
    assign o_extended = ext_q;

endmodule
